// File: rtl/clk_gate_enable_ctrl.sv
// Enable generator for a bank of integrated clock-gating cells: one wake/idle FSM
// per gated domain, with one cascaded parent gate kept open for its children.
module clk_gate_enable_ctrl #(
    parameter int                   NUM_DOMAINS = 5,
    parameter int                   IDLE_CYCLES = 16,
    parameter int                   WAKE_CYCLES = 2,
    parameter int                   PARENT_IDX  = 3,
    parameter logic [NUM_DOMAINS-1:0] CHILD_MASK  = 5'b00100
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_DOMAINS-1:0]             busy,
    input  logic                               force_on,
    output logic [NUM_DOMAINS-1:0]             gate_en,
    output logic [NUM_DOMAINS-1:0]             ready,
    output logic [$clog2(NUM_DOMAINS+1)-1:0]   active_cnt
);

    localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int ACW     = $clog2(NUM_DOMAINS + 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                   state      [NUM_DOMAINS];
    state_t                   state_next [NUM_DOMAINS];
    logic   [CW-1:0]          cnt        [NUM_DOMAINS];
    logic   [CW-1:0]          cnt_next   [NUM_DOMAINS];
    logic   [NUM_DOMAINS-1:0] demand;
    logic                     child_act;
    logic                     parent_ready;
    logic   [NUM_DOMAINS-1:0] gate_next;
    logic   [NUM_DOMAINS-1:0] ready_next;
    logic   [ACW-1:0]         active_next;

    // Outputs are registered from the next-state view so gate_en changes on the
    // same edge the FSM does, straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state[i] <= OFF;
                cnt[i]   <= '0;
            end
            gate_en    <= '0;
            ready      <= '0;
            active_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_DOMAINS; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            gate_en    <= gate_next;
            ready      <= ready_next;
            active_cnt <= active_next;
        end
    end

    always_comb begin
        child_act = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (CHILD_MASK[i]) begin
                child_act = child_act | busy[i] | (state[i] != OFF);
            end
        end
        parent_ready = (state[PARENT_IDX] == ON) || (state[PARENT_IDX] == HOLD);

        demand = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            demand[i]     = busy[i] | ((i == PARENT_IDX) ? child_act : 1'b0);
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                OFF: begin
                    // A child only wakes once its parent's gated clock is stable.
                    if (demand[i] && (!CHILD_MASK[i] || parent_ready)) begin
                        state_next[i] = WAKE;
                        cnt_next[i]   = CW'(WAKE_CYCLES - 1);
                    end
                end
                WAKE: begin
                    if (cnt[i] == '0) begin
                        state_next[i] = ON;
                    end else begin
                        cnt_next[i] = cnt[i] - CW'(1);
                    end
                end
                ON: begin
                    if (!demand[i]) begin
                        state_next[i] = HOLD;
                        cnt_next[i]   = CW'(IDLE_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (demand[i]) begin
                        state_next[i] = ON;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == '0) begin
                        state_next[i] = OFF;
                    end else begin
                        cnt_next[i] = cnt[i] - CW'(1);
                    end
                end
                default: begin
                    state_next[i] = OFF;
                    cnt_next[i]   = '0;
                end
            endcase
        end
    end

    // force_on only masks the outputs; the FSMs keep running underneath it.
    always_comb begin
        gate_next   = '0;
        ready_next  = '0;
        active_next = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            gate_next[i]  = force_on | (state_next[i] != OFF);
            ready_next[i] = force_on | (state_next[i] == ON) | (state_next[i] == HOLD);
        end
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            active_next = active_next + ACW'(gate_next[i]);
        end
    end

endmodule

// File: tb/tb_clk_gate_enable_ctrl.sv
// Randomised and directed bench for clk_gate_enable_ctrl, scored every cycle
// against an age/idle-run model of each gate.
module tb_clk_gate_enable_ctrl;

    localparam int         ND    = 5;
    localparam int         IDLE  = 16;
    localparam int         WAKE  = 2;
    localparam int         PIDX  = 3;
    localparam logic [4:0] CMASK = 5'b00100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [ND-1:0] busy = '0;
    logic          force_on = 1'b0;
    logic [ND-1:0] gate_en;
    logic [ND-1:0] ready;
    logic [2:0]    active_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    bit [ND-1:0] m_open  = '0;
    bit [ND-1:0] m_ready = '0;
    bit          m_force = 1'b0;
    int          age  [ND];
    int          idle [ND];

    clk_gate_enable_ctrl #(
        .NUM_DOMAINS(ND), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE),
        .PARENT_IDX(PIDX), .CHILD_MASK(CMASK)
    ) dut (
        .clk(clk), .rst(rst), .busy(busy), .force_on(force_on),
        .gate_en(gate_en), .ready(ready), .active_cnt(active_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a gate opens on demand, is ready after WAKE edges of age, and
    // closes once IDLE+1 consecutive no-demand samples were taken while ready.
    task automatic modelEdge();
        bit [ND-1:0] open_pre = m_open;
        bit [ND-1:0] rdy_pre  = m_ready;
        bit          cact     = 1'b0;
        bit          dem;
        if (rst) begin
            m_open = '0; m_ready = '0; m_force = 1'b0;
            for (int i = 0; i < ND; i++) begin age[i] = 0; idle[i] = 0; end
            return;
        end
        for (int c = 0; c < ND; c++)
            if (CMASK[c]) cact = cact | busy[c] | open_pre[c];
        for (int i = 0; i < ND; i++) begin
            dem = busy[i] | ((i == PIDX) ? cact : 1'b0);
            if (!open_pre[i]) begin
                if (dem && (!CMASK[i] || rdy_pre[PIDX])) begin
                    m_open[i] = 1'b1; age[i] = 0; idle[i] = 0;
                end
            end else if (!rdy_pre[i]) begin
                age[i]++;
                if (age[i] == WAKE) begin m_ready[i] = 1'b1; idle[i] = 0; end
            end else begin
                idle[i] = dem ? 0 : idle[i] + 1;
                if (idle[i] == IDLE + 1) begin m_open[i] = 1'b0; m_ready[i] = 1'b0; end
            end
        end
        m_force = force_on;
    endtask

    always @(posedge clk) modelEdge();

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_gate_en", gate_en, m_force ? 5'h1f : m_open);
            checkOutput("model_ready", ready, m_force ? 5'h1f : m_ready);
            checkOutput("model_active_cnt", active_cnt, m_force ? ND : $countones(m_open));
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [ND-1:0] b, input logic f, input logic r);
        busy = b; force_on = f; rst = r;
    endtask

    initial begin
        int dens;
        applyStimulus('0, 1'b0, 1'b1);
        tick(3);
        chk_en = 1'b1;
        checkOutput("reset_gate_en", gate_en, 5'b00000);
        checkOutput("reset_ready", ready, 5'b00000);
        checkOutput("reset_active", active_cnt, 0);
        applyStimulus('0, 1'b0, 1'b0);
        tick(50);
        checkOutput("idle_gate_en", gate_en, 5'b00000);

        // Domain 0 wake and sleep.
        applyStimulus(5'b00001, 1'b0, 1'b0);
        tick(1);
        checkOutput("d0_gate_rise", gate_en, 5'b00001);
        checkOutput("d0_active_one", active_cnt, 1);
        tick(1);
        checkOutput("d0_not_ready_yet", ready, 5'b00000);
        tick(1);
        checkOutput("d0_ready_rise", ready, 5'b00001);
        tick(10);
        applyStimulus('0, 1'b0, 1'b0);
        tick(16);
        checkOutput("d0_hold_open", gate_en, 5'b00001);
        tick(1);
        checkOutput("d0_gate_fall", gate_en, 5'b00000);
        checkOutput("d0_ready_fall", ready, 5'b00000);

        // Cascade: child 2 pulls parent 3 open first.
        applyStimulus(5'b00100, 1'b0, 1'b0);
        tick(1);
        checkOutput("casc_parent_open", gate_en, 5'b01000);
        tick(2);
        checkOutput("casc_parent_ready", ready, 5'b01000);
        tick(1);
        checkOutput("casc_child_open", gate_en, 5'b01100);
        tick(2);
        checkOutput("casc_child_ready", ready, 5'b01100);
        tick(5);
        applyStimulus('0, 1'b0, 1'b0);
        tick(16);
        checkOutput("casc_child_hold", gate_en, 5'b01100);
        tick(1);
        checkOutput("casc_child_close", gate_en, 5'b01000);
        tick(16);
        checkOutput("casc_parent_hold", gate_en, 5'b01000);
        tick(1);
        checkOutput("casc_parent_close", gate_en, 5'b00000);

        // force_on pulse while everything is off.
        applyStimulus('0, 1'b1, 1'b0);
        tick(1);
        checkOutput("force_gate_en", gate_en, 5'b11111);
        checkOutput("force_active", active_cnt, 5);
        tick(4);
        checkOutput("force_ready", ready, 5'b11111);
        applyStimulus('0, 1'b0, 1'b0);
        tick(1);
        checkOutput("force_release", gate_en, 5'b00000);

        // Reset mid-operation, then wake restarts from OFF.
        applyStimulus(5'b11111, 1'b0, 1'b0);
        tick(4);
        applyStimulus(5'b11111, 1'b0, 1'b1);
        tick(1);
        checkOutput("midrst_gate_en", gate_en, 5'b00000);
        checkOutput("midrst_ready", ready, 5'b00000);
        applyStimulus(5'b11111, 1'b0, 1'b0);
        tick(1);
        checkOutput("postrst_roots_open", gate_en, 5'b11011);
        checkOutput("postrst_not_ready", ready, 5'b00000);

        // Random phase with varying busy density and occasional force/reset.
        dens = 30;
        for (int c = 0; c < 4000; c++) begin
            logic [ND-1:0] b;
            if (c % 150 == 0) begin
                case ($urandom_range(0, 3))
                    0: dens = 0;
                    1: dens = 4;
                    2: dens = 30;
                    default: dens = 75;
                endcase
            end
            for (int i = 0; i < ND; i++) b[i] = ($urandom_range(0, 99) < dens);
            applyStimulus(b, ($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 3));
            tick(1);
        end

        applyStimulus('0, 1'b0, 1'b0);
        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/clk_gate_enable_ctrl.md
Name: clk_gate_enable_ctrl

Overview:
- Generates the enable inputs for the integrated clock-gating cells (CLKGATE_X1 class) that drive gated register banks.
- Each gated domain has a per-domain FSM that:
  - opens the gate when there is work,
  - reports when the gated clock is stable,
  - closes the gate after a programmable idle time.
- Supports one cascaded parent gate: a gate fed by another gate's output clock. The parent is kept open while any child needs it.
- Sits at the root of the clock tree, next to the gate cells it controls.

Parameters:
- NUM_DOMAINS, 5, number of gated domains; domain i drives gate_en[i].
- IDLE_CYCLES, 16, consecutive no-demand cycles before a gate closes; must be >= 1.
- WAKE_CYCLES, 2, cycles after gate open before ready is asserted; must be >= 1.
- PARENT_IDX, 3, index of the domain whose gated clock feeds the cascaded child gates.
- CHILD_MASK, 5'b00100, bit i set means domain i is clocked through domain PARENT_IDX; bit PARENT_IDX must be 0.

Ports:
- clk  input  1  clock; the ungated root clock.
- rst  input  1  reset; synchronous, active-high.
- busy  input  NUM_DOMAINS  per-domain work request; level-sensitive; sampled on the rising edge of clk.
- force_on  input  1  test/scan override; holds all gates open.
- gate_en  output  NUM_DOMAINS  to the gate enable pins; registered.
- ready  output  NUM_DOMAINS  gated clock running and stable; registered.
- active_cnt  output  $clog2(NUM_DOMAINS+1)  popcount of gate_en; registered, same cycle as gate_en.

Behaviour:
- Reset: all FSMs go to OFF and all counters to 0. gate_en=0, ready=0, active_cnt=0 on the edge rst is sampled high. Reset mid-wake or mid-hold closes the gate at that edge; no ordering is enforced.
- child_act = OR over i in CHILD_MASK of (busy[i] | state[i]!=OFF).
- demand[i] = busy[i], plus child_act when i==PARENT_IDX.
- Per-domain FSM, all transitions on the clk edge:
  - OFF: gate_en=0, ready=0.
    - Root domain: demand -> WAKE, with cnt=WAKE_CYCLES-1.
    - Child domain: demand and ready[PARENT_IDX]==1 -> WAKE; otherwise it stays OFF while its busy is already propagating demand to the parent.
  - WAKE: gate_en=1, ready=0.
    - cnt==0 -> ON; otherwise cnt-1.
    - Loss of demand in WAKE does not abort; the FSM continues to ON.
  - ON: gate_en=1, ready=1.
    - No demand -> HOLD, with cnt=IDLE_CYCLES-1.
  - HOLD: gate_en=1, ready=1.
    - Demand -> ON; the counter is discarded.
    - Otherwise cnt==0 -> OFF, else cnt-1.
- Latency:
  - gate_en rises 1 edge after busy is first sampled high.
  - ready rises WAKE_CYCLES+1 edges after busy is first sampled high.
  - gate_en and ready fall IDLE_CYCLES+1 edges after demand is first sampled low, provided demand stays low throughout.
- Cascade:
  - The parent never enters OFF while any child is non-OFF.
  - If a child requests while the parent is OFF, the parent wakes first. The child enters WAKE on the edge after ready[PARENT_IDX] is 1, so child ready arrives 2*(WAKE_CYCLES+1) edges after the request.
  - If the parent is in HOLD, it returns to ON in the same edge that the child enters WAKE.
- force_on:
  - Registered with 1 cycle latency. While asserted, gate_en=all ones, ready=all ones, and active_cnt=NUM_DOMAINS.
  - FSMs keep running underneath. On deassertion, the outputs revert to the FSM values on the next edge with no glitch sequencing.
- Counter widths: $clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1) bits; no wrap, because the counter reloads on state entry.
- gate_en is glitch-free by construction: it comes directly from a flop, with no combinational path from busy.

Test Plan:
- Reset then idle: rst high 3 cycles, busy=0 -> gate_en=0, ready=0, active_cnt=0 for 50 cycles.
- Wake/sleep, domain 0, defaults: busy[0]=1 at edge 10 -> gate_en[0]=1 after edge 10, ready[0]=1 after edge 12. busy[0]=0 sampled at edge 30 -> gate_en[0] falls after edge 47.
- Idle retrigger: busy[1] low 10 cycles, then high 1 cycle during HOLD -> stays ON, gate never closes. Then low 16 cycles -> closes exactly 17 edges after the final low sample.
- Cascade: all OFF, busy[2]=1 at edge 0 -> gate_en[3] after edge 0, ready[3] after edge 2, gate_en[2] after edge 3, ready[2] after edge 5. Drop busy[2] -> domain 2 closes after 17 edges; domain 3 closes 17 edges after that.
- force_on pulse of 5 cycles while all OFF -> gate_en=5'b11111 and active_cnt=5 from the next edge for 5 cycles, then back to 0. FSM states unchanged.
- Reset mid-operation: rst at an edge with domains 0 and 3 in HOLD and domain 2 in WAKE -> all outputs 0 at that edge. After release with busy held high, wake latency restarts from OFF.
